// File: rtl/ysyx_idu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_idu_pkg
//  Description : Shared decode definitions for the IDU and downstream stages:
//                instruction class codes, immediate formats, 7-bit opcodes and
//                an opcode classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_idu_pkg;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OPIMM   = 4'd7,
        CLS_OP      = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd15
    } cls_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        cls_e cls;
        fmt_e fmt;
        logic use_rs1;
        logic use_rs2;
        logic has_rd;
    } op_info_t;

    // Every legal opcode ends in 2'b11, so a full 7-bit match also rejects
    // compressed/short encodings.
    function automatic op_info_t decode_opcode(input logic [6:0] opc);
        op_info_t info;
        info = '{cls: CLS_ILLEGAL, fmt: FMT_R, use_rs1: 1'b0, use_rs2: 1'b0, has_rd: 1'b0};
        case (opc)
            OPC_LUI:    info = '{cls: CLS_LUI,    fmt: FMT_U, use_rs1: 1'b0, use_rs2: 1'b0, has_rd: 1'b1};
            OPC_AUIPC:  info = '{cls: CLS_AUIPC,  fmt: FMT_U, use_rs1: 1'b0, use_rs2: 1'b0, has_rd: 1'b1};
            OPC_JAL:    info = '{cls: CLS_JAL,    fmt: FMT_J, use_rs1: 1'b0, use_rs2: 1'b0, has_rd: 1'b1};
            OPC_JALR:   info = '{cls: CLS_JALR,   fmt: FMT_I, use_rs1: 1'b1, use_rs2: 1'b0, has_rd: 1'b1};
            OPC_BRANCH: info = '{cls: CLS_BRANCH, fmt: FMT_B, use_rs1: 1'b1, use_rs2: 1'b1, has_rd: 1'b0};
            OPC_LOAD:   info = '{cls: CLS_LOAD,   fmt: FMT_I, use_rs1: 1'b1, use_rs2: 1'b0, has_rd: 1'b1};
            OPC_STORE:  info = '{cls: CLS_STORE,  fmt: FMT_S, use_rs1: 1'b1, use_rs2: 1'b1, has_rd: 1'b0};
            OPC_OPIMM:  info = '{cls: CLS_OPIMM,  fmt: FMT_I, use_rs1: 1'b1, use_rs2: 1'b0, has_rd: 1'b1};
            OPC_OP:     info = '{cls: CLS_OP,     fmt: FMT_R, use_rs1: 1'b1, use_rs2: 1'b1, has_rd: 1'b1};
            OPC_FENCE:  info = '{cls: CLS_FENCE,  fmt: FMT_I, use_rs1: 1'b0, use_rs2: 1'b0, has_rd: 1'b0};
            OPC_SYSTEM: info = '{cls: CLS_SYSTEM, fmt: FMT_I, use_rs1: 1'b0, use_rs2: 1'b0, has_rd: 1'b0};
            default:    ;
        endcase
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_idu_imm.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_idu_imm
//  Description : Combinational immediate generator; sign-extends the
//                I/S/B/U/J immediate selected by fmt_i, zero for R-type.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_idu_imm
    import ysyx_idu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    // opcode bits [6:0] never contribute to an immediate
    input  logic [31:7]       inst_i,
    input  fmt_e              fmt_i,
    output logic [DATA_W-1:0] imm_o
);

    logic [31:0] w_imm32;

    // Assemble the 32-bit immediate for the selected format
    always_comb begin
        w_imm32 = '0;
        case (fmt_i)
            FMT_I:   w_imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S:   w_imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B:   w_imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                                inst_i[11:8], 1'b0};
            FMT_U:   w_imm32 = {inst_i[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                                inst_i[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign imm_o = DATA_W'(signed'(w_imm32));

endmodule
`default_nettype wire

// File: rtl/ysyx_idu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_idu
//  Description : Instruction decode stage with a single-entry output register,
//                a register busy scoreboard for RAW stalls and redirect flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_idu
    import ysyx_idu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NR_REG = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_valid,
    output logic              ready_o,
    input  logic [DATA_W-1:0] inst,
    input  logic [ADDR_W-1:0] pc,
    output logic              valid_o,
    input  logic              next_ready,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic              rd_we_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [2:0]        funct3_o,
    output logic              funct7b5_o,
    output logic [3:0]        cls_o,
    output logic              illegal_o
);

    localparam logic [5:0] C_NR_REG = 6'(NR_REG);

    // ---------------- combinational decode of the incoming word -----------
    op_info_t          w_op;
    logic [4:0]        w_rd, w_rs1, w_rs2;
    logic              w_bad_reg, w_illegal, w_rd_we;
    logic [DATA_W-1:0] w_imm;

    assign w_op  = decode_opcode(inst[6:0]);
    assign w_rd  = inst[11:7];
    assign w_rs1 = inst[19:15];
    assign w_rs2 = inst[24:20];

    // Only register fields the instruction actually uses can make it illegal
    assign w_bad_reg = (w_op.has_rd  & ({1'b0, w_rd}  >= C_NR_REG))
                     | (w_op.use_rs1 & ({1'b0, w_rs1} >= C_NR_REG))
                     | (w_op.use_rs2 & ({1'b0, w_rs2} >= C_NR_REG));
    assign w_illegal = (w_op.cls == CLS_ILLEGAL) | w_bad_reg;
    assign w_rd_we   = w_op.has_rd & (w_rd != 5'd0) & ~w_illegal;

    ysyx_idu_imm #(
        .DATA_W (DATA_W)
    ) u_imm (
        .inst_i (inst[31:7]),
        .fmt_i  (w_op.fmt),
        .imm_o  (w_imm)
    );

    // ---------------- held instruction and scoreboard state ---------------
    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] inst_q, imm_q;
    logic [4:0]        rs1_q, rs2_q, rd_q;
    logic              rd_we_q, illegal_q, use_rs1_q, use_rs2_q;
    logic [3:0]        cls_q;
    logic [NR_REG-1:0] busy_q, busy_d;

    logic w_rs1_busy, w_rs2_busy, w_hazard, w_issue, w_cap;

    // Look up the busy bit of each used source; indices past NR_REG never hit
    always_comb begin
        w_rs1_busy = 1'b0;
        w_rs2_busy = 1'b0;
        for (int r = 1; r < NR_REG; r++) begin
            if (rs1_q == 5'(r)) w_rs1_busy = busy_q[r];
            if (rs2_q == 5'(r)) w_rs2_busy = busy_q[r];
        end
    end

    assign w_hazard = vld_q & ((use_rs1_q & w_rs1_busy) | (use_rs2_q & w_rs2_busy));
    assign valid_o  = vld_q & ~w_hazard;
    assign ready_o  = ~vld_q | (next_ready & ~w_hazard);
    assign w_issue  = valid_o & next_ready;
    assign w_cap    = prev_valid & ready_o & ~flush;

    // Valid flag: flush dominates, then capture, then drain on issue
    always_comb begin
        vld_d = vld_q;
        if (flush)        vld_d = 1'b0;
        else if (w_cap)   vld_d = 1'b1;
        else if (w_issue) vld_d = 1'b0;
    end

    // Scoreboard next state: writeback clears first so a same-cycle issue wins
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NR_REG; r++) begin
            if (wb_valid && (wb_rd == 5'(r)))               busy_d[r] = 1'b0;
            if (w_issue && rd_we_q && (rd_q == 5'(r)))      busy_d[r] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Control and scoreboard registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            busy_q <= '0;
        end else begin
            vld_q  <= vld_d;
            busy_q <= busy_d;
        end
    end

    // Decoded payload register, loaded only on capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q      <= '0;
            inst_q    <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            illegal_q <= 1'b0;
            use_rs1_q <= 1'b0;
            use_rs2_q <= 1'b0;
            cls_q     <= '0;
        end else if (w_cap) begin
            pc_q      <= pc;
            inst_q    <= inst;
            imm_q     <= w_imm;
            rs1_q     <= w_rs1;
            rs2_q     <= w_rs2;
            rd_q      <= w_rd;
            rd_we_q   <= w_rd_we;
            illegal_q <= w_illegal;
            use_rs1_q <= w_op.use_rs1;
            use_rs2_q <= w_op.use_rs2;
            cls_q     <= w_op.cls;
        end
    end

    assign pc_o       = pc_q;
    assign inst_o     = inst_q;
    assign imm_o      = imm_q;
    assign rs1_o      = rs1_q;
    assign rs2_o      = rs2_q;
    assign rd_o       = rd_q;
    assign rd_we_o    = rd_we_q;
    assign illegal_o  = illegal_q;
    assign cls_o      = cls_q;
    assign funct3_o   = inst_q[14:12];
    assign funct7b5_o = inst_q[30];

endmodule
`default_nettype wire

// File: tb/tb_ysyx_idu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_idu
//  Description : Self-checking bench for ysyx_idu: directed scenarios followed
//                by random traffic, all outputs compared every cycle against a
//                behavioural model of the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_idu;
    import ysyx_idu_pkg::*;

    logic        clk, rst, prev_valid, ready_o, valid_o, next_ready, flush;
    logic        wb_valid, rd_we_o, funct7b5_o, illegal_o;
    logic [31:0] inst, pc, pc_o, inst_o, imm_o;
    logic [4:0]  wb_rd, rs1_o, rs2_o, rd_o;
    logic [2:0]  funct3_o;
    logic [3:0]  cls_o;

    ysyx_idu #(.ADDR_W(32), .DATA_W(32), .NR_REG(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .prev_valid (prev_valid),
        .ready_o    (ready_o),
        .inst       (inst),
        .pc         (pc),
        .valid_o    (valid_o),
        .next_ready (next_ready),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .pc_o       (pc_o),
        .inst_o     (inst_o),
        .rs1_o      (rs1_o),
        .rs2_o      (rs2_o),
        .rd_o       (rd_o),
        .rd_we_o    (rd_we_o),
        .imm_o      (imm_o),
        .funct3_o   (funct3_o),
        .funct7b5_o (funct7b5_o),
        .cls_o      (cls_o),
        .illegal_o  (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  cls;
        logic [31:0] imm;
        bit          u1, u2, hasrd, ill;
    } ref_t;

    function automatic ref_t ref_dec(input logic [31:0] i);
        ref_t d;
        d = '{cls: CLS_ILLEGAL, imm: 32'h0, u1: 0, u2: 0, hasrd: 0, ill: 0};
        case (i[6:0])
            7'h37: begin d.cls = CLS_LUI;    d.imm = {i[31:12], 12'h000}; d.hasrd = 1; end
            7'h17: begin d.cls = CLS_AUIPC;  d.imm = {i[31:12], 12'h000}; d.hasrd = 1; end
            7'h6F: begin d.cls = CLS_JAL;    d.hasrd = 1;
                         d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            7'h67: begin d.cls = CLS_JALR;   d.imm = {{20{i[31]}}, i[31:20]}; d.u1 = 1; d.hasrd = 1; end
            7'h63: begin d.cls = CLS_BRANCH; d.u1 = 1; d.u2 = 1;
                         d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
            7'h03: begin d.cls = CLS_LOAD;   d.imm = {{20{i[31]}}, i[31:20]}; d.u1 = 1; d.hasrd = 1; end
            7'h23: begin d.cls = CLS_STORE;  d.imm = {{20{i[31]}}, i[31:25], i[11:7]}; d.u1 = 1; d.u2 = 1; end
            7'h13: begin d.cls = CLS_OPIMM;  d.imm = {{20{i[31]}}, i[31:20]}; d.u1 = 1; d.hasrd = 1; end
            7'h33: begin d.cls = CLS_OP;     d.u1 = 1; d.u2 = 1; d.hasrd = 1; end
            7'h0F: begin d.cls = CLS_FENCE;  d.imm = {{20{i[31]}}, i[31:20]}; end
            7'h73: begin d.cls = CLS_SYSTEM; d.imm = {{20{i[31]}}, i[31:20]}; end
            default: ;
        endcase
        d.ill = (d.cls == CLS_ILLEGAL)
              || (d.hasrd && i[11:7]  >= 16)
              || (d.u1    && i[19:15] >= 16)
              || (d.u2    && i[24:20] >= 16);
        return d;
    endfunction

    bit          m_known = 0;
    bit          m_vld   = 0;
    bit          m_fresh = 1;
    bit          m_busy[32];
    logic [31:0] m_inst  = 0;
    logic [31:0] m_pc    = 0;

    function automatic bit m_hazard();
        ref_t d;
        d = ref_dec(m_inst);
        return m_vld && ((d.u1 && m_busy[m_inst[19:15]]) || (d.u2 && m_busy[m_inst[24:20]]));
    endfunction

    task automatic check_outputs();
        ref_t d;
        bit   hz, we;
        if (!m_known) return;
        d  = ref_dec(m_inst);
        hz = m_hazard();
        we = !m_fresh && d.hasrd && (m_inst[11:7] != 0) && !d.ill;
        chk("valid_o",    valid_o,    32'(m_vld && !hz));
        chk("ready_o",    ready_o,    32'(!m_vld || (next_ready && !hz)));
        chk("pc_o",       pc_o,       m_pc);
        chk("inst_o",     inst_o,     m_inst);
        chk("rs1_o",      rs1_o,      32'(m_inst[19:15]));
        chk("rs2_o",      rs2_o,      32'(m_inst[24:20]));
        chk("rd_o",       rd_o,       32'(m_inst[11:7]));
        chk("funct3_o",   funct3_o,   32'(m_inst[14:12]));
        chk("funct7b5_o", funct7b5_o, 32'(m_inst[30]));
        chk("rd_we_o",    rd_we_o,    32'(we));
        chk("imm_o",      imm_o,      m_fresh ? 32'h0 : d.imm);
        chk("cls_o",      cls_o,      m_fresh ? 32'h0 : 32'(d.cls));
        chk("illegal_o",  illegal_o,  32'(!m_fresh && d.ill));
    endtask

    // Advance the model by one rising edge using the inputs currently driven
    task automatic model_update();
        ref_t d;
        bit   hz, issue, rdy, cap, we;
        if (!rst) begin
            m_known = 1; m_vld = 0; m_fresh = 1; m_inst = 0; m_pc = 0;
            foreach (m_busy[k]) m_busy[k] = 0;
            return;
        end
        d     = ref_dec(m_inst);
        hz    = m_hazard();
        issue = m_vld && !hz && next_ready;
        rdy   = !m_vld || (next_ready && !hz);
        cap   = prev_valid && rdy && !flush;
        we    = !m_fresh && d.hasrd && (m_inst[11:7] != 0) && !d.ill;
        if (wb_valid) m_busy[wb_rd] = 0;
        if (issue && we) m_busy[m_inst[11:7]] = 1;
        m_busy[0] = 0;
        if (flush)      m_vld = 0;
        else if (cap)   m_vld = 1;
        else if (issue) m_vld = 0;
        if (cap) begin m_inst = inst; m_pc = pc; m_fresh = 0; end
    endtask

    task automatic step(input bit rn, input bit pv, input logic [31:0] in, input logic [31:0] p,
                        input bit nr, input bit fl, input bit wv, input logic [4:0] wr);
        rst = rn; prev_valid = pv; inst = in; pc = p; next_ready = nr;
        flush = fl; wb_valid = wv; wb_rd = wr;
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  opcs [12];
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h5B};
        w = $urandom;
        if ($urandom_range(0, 19) == 0) return w;
        w[6:0]   = opcs[$urandom_range(0, 11)];
        w[11:7]  = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
        w[19:15] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
        w[24:20] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
        return w;
    endfunction

    localparam logic [31:0] I_ADDI  = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_ADD   = 32'h00108133;  // add  x2,x1,x1
    localparam logic [31:0] I_LUI   = 32'h123451B7;  // lui  x3,0x12345
    localparam logic [31:0] I_SW    = 32'hFE302E23;  // sw   x3,-4(x0)
    localparam logic [31:0] I_JAL   = 32'hFF9FF0EF;  // jal  x1,-8
    localparam logic [31:0] I_ADDIX = 32'h00100A13;  // addi x20,x0,1

    initial begin
        rst = 0; prev_valid = 0; inst = 0; pc = 0; next_ready = 0;
        flush = 0; wb_valid = 0; wb_rd = 0;
        @(posedge clk); #1;

        // reset and idle
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        step(1, 0, 0, 0, 1, 0, 0, 0);

        // addi then dependent add
        step(1, 1, I_ADDI, 32'h80000000, 1, 0, 0, 0);
        chk("addi_valid", valid_o, 1);
        chk("addi_cls",   cls_o,   32'(CLS_OPIMM));
        chk("addi_imm",   imm_o,   32'd5);
        chk("addi_rd",    rd_o,    32'd1);
        chk("addi_we",    rd_we_o, 1);
        step(1, 1, I_ADD, 32'h80000004, 1, 0, 0, 0);
        chk("add_stall_valid", valid_o, 0);
        chk("add_stall_ready", ready_o, 0);
        step(1, 0, 0, 0, 1, 0, 1, 5'd1);
        chk("add_release", valid_o, 1);

        // lui then sw with writeback of x3 between
        step(1, 1, I_LUI, 32'h80000008, 1, 0, 0, 0);
        chk("lui_imm", imm_o, 32'h12345000);
        step(1, 1, I_SW, 32'h8000000C, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 1, 5'd3);
        chk("sw_imm", imm_o, 32'hFFFFFFFC);
        chk("sw_we",  rd_we_o, 0);

        // back-pressure then no-bubble replacement
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_inst", inst_o, I_SW);
        step(1, 1, I_JAL, 32'h80000010, 1, 0, 0, 0);
        chk("jal_valid", valid_o, 1);
        chk("jal_imm",   imm_o,   32'hFFFFFFF8);

        // flush with concurrent fetch drops both
        step(1, 1, I_ADDI, 32'h80000014, 0, 1, 0, 0);
        chk("flush_valid", valid_o, 0);
        chk("flush_pc",    pc_o,    32'h80000010);
        // flush while the held jal issues keeps busy[1]
        step(1, 1, I_JAL, 32'h80000020, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0, 0);
        step(1, 1, I_ADD, 32'h80000024, 1, 0, 0, 0);
        chk("flush_busy_kept", valid_o, 0);
        step(1, 0, 0, 0, 1, 0, 1, 5'd1);

        // illegal encodings
        step(1, 1, 32'h0, 32'h80000030, 1, 0, 0, 0);
        chk("zero_ill", illegal_o, 1);
        chk("zero_we",  rd_we_o,   0);
        step(1, 1, I_ADDIX, 32'h80000034, 1, 0, 0, 0);
        chk("x20_ill", illegal_o, 1);
        chk("x20_we",  rd_we_o,   0);
        step(1, 0, 0, 0, 1, 0, 0, 0);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 9) < 7),
                 rand_inst(),
                 $urandom,
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 3),
                 5'($urandom_range(0, 6)));
        end
        step(1, 0, 0, 0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
